mult4u_dmr_scheduler: RTL and testbench

- Shares one combinational 4x4 unsigned multiplier core among NREQ requesters using round-robin arbitration.
- Each operation runs twice on the core, first A*B and then B*A with operands swapped, so a single fault hits different gate paths; the two products are compared.
- On mismatch the block retries up to MAX_RETRY times, then returns the result with an error flag.
- Sits between the requester fabric and the fault-resilient multiplier netlists; any mult4u variant plugs in as the core.

---
 rtl/mult4u_sched_pkg.sv | 19 +
 rtl/mult4u_core.sv | 17 +
 rtl/mult4u_dmr_scheduler.sv | 137 +++++++++++++
 tb/tb_mult4u_dmr_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult4u_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult4u_sched_pkg : shared types/constants for the DMR multiplier scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
package mult4u_sched_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mult4u_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult4u_core : combinational 4x4 -> 8 unsigned multiplier core
// Revision: 1.0
// ---------------------------------------------------------------------------
module mult4u_core
  import mult4u_sched_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  assign p = {{(PW-OPW){1'b0}}, a} * {{(PW-OPW){1'b0}}, b};

endmodule
`default_nettype wire

// File: rtl/mult4u_dmr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult4u_dmr_scheduler : round-robin shared multiplier with swapped-operand
// dual execution, bounded retry and saturating fault counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mult4u_dmr_scheduler
  import mult4u_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNTW      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  input  logic                chk_en,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PW-1:0]       rsp_p,
  output logic                rsp_err,
  output logic [CNTW-1:0]     fault_cnt
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_r;
  logic [OPW-1:0]   a_r, b_r;
  logic             chk_r;
  logic [PW-1:0]    p1;
  logic             err_r;
  logic [RW-1:0]    retry;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [OPW-1:0]   core_a, core_b;
  logic [PW-1:0]    core_p;
  logic             mismatch;

  // Descending scan so the lowest offset from rr_ptr is the last write and wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  assign req_ready = (state == IDLE && gnt_found && rst_n) ? (NREQ'(1) << gnt_idx) : '0;

  // Second pass swaps operands so a single fault exercises different gate paths.
  assign core_a   = (state == EXEC2) ? b_r : a_r;
  assign core_b   = (state == EXEC2) ? a_r : b_r;
  assign mismatch = (core_p != p1);

  mult4u_core u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gnt_found) state_nxt = EXEC1;
      EXEC1: state_nxt = chk_r ? EXEC2 : RESP;
      EXEC2: begin
        if (mismatch && retry < RETRY_MAX) state_nxt = EXEC1;
        else                               state_nxt = RESP;
      end
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      chk_r     <= 1'b0;
      p1        <= '0;
      err_r     <= 1'b0;
      retry     <= '0;
      fault_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            a_r    <= req_a[int'(gnt_idx)*OPW +: OPW];
            b_r    <= req_b[int'(gnt_idx)*OPW +: OPW];
            id_r   <= gnt_idx;
            chk_r  <= chk_en;
            rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
            err_r  <= 1'b0;
            retry  <= '0;
          end
        end
        EXEC1: p1 <= core_p;
        EXEC2: begin
          if (mismatch) begin
            if (fault_cnt != '1) fault_cnt <= fault_cnt + CNTW'(1);
            if (retry < RETRY_MAX) retry <= retry + RW'(1);
            else                   err_r <= 1'b1;
          end
        end
        RESP: if (rsp_ready) retry <= '0;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_r;
  assign rsp_p     = p1;
  assign rsp_err   = err_r;

endmodule
`default_nettype wire

// File: tb/tb_mult4u_dmr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult4u_dmr_scheduler : self-checking bench with scoreboard and vectors
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mult4u_dmr_scheduler;
  import mult4u_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic              chk_en, rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_p;
  logic              rsp_err;
  logic [CNTW-1:0]   fault_cnt;

  always #5 clk = ~clk;

  mult4u_dmr_scheduler #(.NREQ(NREQ), .IDW(IDW), .MAX_RETRY(2), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .chk_en    (chk_en),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .fault_cnt (fault_cnt)
  );

  typedef struct {
    logic [7:0] p;
    int         id;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       chk;
    logic [7:0] exp_p;
    int         exp_lat;
    int         hold;
  } vec_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_ptr = 0;
  logic exp_err = 1'b0;
  logic inj_en  = 1'b0;
  logic [7:0] inj_p = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Fault injection on the core product, active only during the swapped pass.
  always @(inj_en or inj_p or dut.state) begin
    if (inj_en && dut.state == EXEC2) force dut.core_p = inj_p;
    else                              release dut.core_p;
  end

  // Grant model + scoreboard push on accept, pop/compare on response handshake.
  always @(negedge clk) begin
    int   g, idx;
    exp_t e;
    if (rst_n) begin
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (model_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g < 0) begin
          n_tests++; n_fail++;
          $display("FAIL grant_without_request: req_ready=0x%0h req_valid=0x%0h", req_ready, req_valid);
        end else begin
          check("grant_onehot", 32'(req_ready), 32'(1) << g);
          e.p   = 8'(req_a[g*4 +: 4]) * 8'(req_b[g*4 +: 4]);
          e.id  = g;
          e.err = exp_err;
          sb.push_back(e);
          gnt_log.push_back(g);
          model_ptr = (g + 1) % NREQ;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_rsp: id=%0d p=0x%0h with empty scoreboard", rsp_id, rsp_p);
        end else begin
          e = sb.pop_front();
          check("rsp_id",  32'(rsp_id),  32'(e.id));
          check("rsp_p",   32'(rsp_p),   32'(e.p));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; chk_en = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    sb.delete(); gnt_log.delete(); model_ptr = 0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
    rsp_ready = 1'b0;
  endtask

  // Single request from requester 0; latency counted in cycles after the ready cycle.
  task automatic run_single(input vec_t v);
    bit found;
    bit seen;
    int lat;
    req_a[3:0] = v.a; req_b[3:0] = v.b; chk_en = v.chk; req_valid = 4'b0001; rsp_ready = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (req_ready[0]) found = 1;
      else tick();
    end
    check("accept", 32'(found), 32'd1);
    tick();
    req_valid = '0; chk_en = 1'b0;
    lat = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1;
      else tick();
    end
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("resp_p_first", 32'(rsp_p), 32'(v.exp_p));
    check("resp_err_first", 32'(rsp_err), 32'(exp_err));
    for (int h = 0; h < v.hold; h++) begin
      tick(); @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_p", 32'(rsp_p), 32'(v.exp_p));
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    tick(); rsp_ready = 1'b0;
  endtask

  vec_t vecs[6];
  int   rr_exp[5];

  initial begin
    bit found;

    vecs[0] = '{a: 4'd15, b: 4'd15, chk: 1'b1, exp_p: 8'hE1, exp_lat: 3, hold: 0};
    vecs[1] = '{a: 4'd0,  b: 4'd9,  chk: 1'b0, exp_p: 8'h00, exp_lat: 2, hold: 0};
    vecs[2] = '{a: 4'd7,  b: 4'd9,  chk: 1'b1, exp_p: 8'h3F, exp_lat: 3, hold: 2};
    vecs[3] = '{a: 4'd3,  b: 4'd5,  chk: 1'b1, exp_p: 8'h0F, exp_lat: 3, hold: 0};
    vecs[4] = '{a: 4'd15, b: 4'd1,  chk: 1'b0, exp_p: 8'h0F, exp_lat: 2, hold: 1};
    vecs[5] = '{a: 4'd12, b: 4'd13, chk: 1'b1, exp_p: 8'h9C, exp_lat: 3, hold: 0};
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset values, with all requests valid to show req_ready is held low.
    rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; chk_en = 1'b1; rsp_ready = 1'b0;
    #2;
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id",    32'(rsp_id),    32'd0);
    check("reset_rsp_p",     32'(rsp_p),     32'd0);
    check("reset_rsp_err",   32'(rsp_err),   32'd0);
    check("reset_fault_cnt", 32'(fault_cnt), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);

    do_reset();
    for (int i = 0; i < 6; i++) run_single(vecs[i]);
    check("fault_cnt_clean", 32'(fault_cnt), 32'd0);
    check("sb_after_table", 32'(sb.size()), 32'd0);

    // Round robin with all four requesters continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*4 +: 4] = 4'(i + 1);
      req_b[i*4 +: 4] = 4'd3;
    end
    chk_en = 1'b1; rsp_ready = 1'b1; req_valid = '1;
    for (int c = 0; c < 80 && gnt_log.size() < 5; c++) @(posedge clk);
    #1;
    req_valid = '0;
    check("rr_grant_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) check("rr_order", 32'(gnt_log[i]), 32'(rr_exp[i]));
    drain();

    // Backpressure: req0 held in RESP while req1 waits.
    do_reset();
    req_a[3:0] = 4'd7; req_b[3:0] = 4'd9; req_a[7:4] = 4'd2; req_b[7:4] = 4'd4;
    chk_en = 1'b1; req_valid = 4'b0011; rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (rsp_valid) found = 1;
      else tick();
    end
    check("bp_rsp_seen", 32'(found), 32'd1);
    for (int h = 0; h < 5; h++) begin
      tick(); @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_p", 32'(rsp_p), 32'h3F);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_at_hs", 32'(req_ready), 32'd0);
    tick(); rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_grant1_next", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    drain();

    // Fault injection in the swapped pass only: all retries exhausted.
    do_reset();
    exp_err = 1'b1; inj_p = 8'd31; inj_en = 1'b1;
    run_single('{a: 4'd5, b: 4'd6, chk: 1'b1, exp_p: 8'h1E, exp_lat: 7, hold: 0});
    check("fault_cnt_3", 32'(fault_cnt), 32'd3);
    run_single('{a: 4'd5, b: 4'd6, chk: 1'b1, exp_p: 8'h1E, exp_lat: 7, hold: 0});
    check("fault_cnt_6", 32'(fault_cnt), 32'd6);
    inj_en = 1'b0; exp_err = 1'b0;
    check("sb_after_fault", 32'(sb.size()), 32'd0);

    // Reset during EXEC2: rr_ptr is 1 here, so a grant to req0 afterwards shows it cleared.
    req_a[3:0] = 4'd3; req_b[3:0] = 4'd3; chk_en = 1'b1; req_valid = 4'b0001;
    @(negedge clk);
    check("rst_mid_accept", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    tick();
    check("rst_mid_in_exec2", 32'(dut.state), 32'(EXEC2));
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {rsp_valid, rsp_id, rsp_p, rsp_err, fault_cnt, req_ready}, 32'd0);
    sb.delete(); gnt_log.delete(); model_ptr = 0;
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*4 +: 4] = 4'(i + 2);
      req_b[i*4 +: 4] = 4'(9 - i);
    end
    req_valid = '1;
    @(negedge clk);
    check("rst_next_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    drain();

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
